csr_unit_m: RTL and testbench
=============================

// Module: csr_unit_m
// PURPOSE
//  Parametrised machine-mode CSR unit; next generation of the core's M-mode CSR file.
//  Executes CSRRW/RS/RC read-modify-write internally, flags illegal accesses and handles trap entry/MRET.
//  Manages mstatus.MIE/MPIE, mie/mip, vectored or direct mtvec, and NUM_HPM event counters plus mcountinhibit.
//  Sits at the WB stage; feeds trap target, MEPC and interrupt request to the fetch/redirect logic.
// PARAMETERS
//  NUM_HPM      3            number of mhpmcounter3.. implemented (0..29); others read 0, writes ignored
//  VECTOR_EN    1            1: mtvec.MODE=1 legal (vectored); 0: MODE bits forced to 0
//  RESET_MTVEC  32'h0000_0000 mtvec reset value (low 2 bits masked per VECTOR_EN)
// PORTS
//  CLK             in  1        clock
//  RST             in  1        reset, synchronous, active-high
//  CSR_VALID       in  1        CSR instruction executes this cycle
//  CSR_OP          in  2        01 RW, 10 RS, 11 RC; 00 = no-op
//  CSR_ADDR        in  12       target CSR
//  CSR_SRC         in  32       rs1 value or zero-extended uimm
//  CSR_WR_EN       in  1        write intent (RW always; RS/RC when rs1/uimm != 0)
//  INSN_RETIRE     in  1        one instruction retires this cycle
//  HPM_EVENT       in  NUM_HPM  per-counter increment strobes (width max(NUM_HPM,1))
//  IRQ_SW/TIMER/EXT in 1 each   level interrupt lines -> mip.MSIP/MTIP/MEIP
//  TRAP_VALID      in  1        trap taken at WB
//  TRAP_IS_INT     in  1        trap is interrupt
//  TRAP_CAUSE      in  31       exception/interrupt code
//  TRAP_PC         in  32       faulting/interrupted PC
//  TRAP_TVAL       in  32       mtval value
//  MRET            in  1        MRET retires
//  CSR_RDATA_REG   out 32       old CSR value, registered (valid cycle after access)
//  CSR_ILLEGAL     out 1        registered illegal-access flag
//  TRAP_TARGET     out 32       handler address (combinational)
//  MEPC_OUT        out 32       current mepc (MRET target)
//  IRQ_REQ         out 1        interrupt pending and enabled
//  IRQ_CODE        out 4        highest-priority pending code (11 > 3 > 7)
// BEHAVIOUR
//  - Reset: all CSRs 0 except mtvec=RESET_MTVEC; CSR_RDATA_REG=0, CSR_ILLEGAL=0, IRQ_REQ=0.
//  - Implemented: mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcountinhibit,
//    mcycle(h), minstret(h), mhpmcounter3..(3+NUM_HPM-1)(h), mhpmevent* (read 0). mip read-only.
//  - Access at cycle N: old value -> CSR_RDATA_REG at N+1; new value visible from N+1.
//    Write value: RW=SRC, RS=old|SRC, RC=old&~SRC; applied only if CSR_WR_EN and not illegal.
//  - Illegal (CSR_ILLEGAL=1 at N+1, no state change): unimplemented addr, or CSR_WR_EN to addr[11:10]==2'b11.
//  - WARL: mstatus keeps only MIE(3), MPIE(7), MPP(12:11) fixed 2'b11; mepc[1:0]=0; mie keeps 3,7,11;
//    mtvec[1] = 0, mtvec[0] = VECTOR_EN ? wdata[0] : 0; mcountinhibit keeps bits 0,2,3..(2+NUM_HPM).
//  - Counters 64-bit, wrap to 0; increment each cycle (mcycle), on INSN_RETIRE (minstret), on HPM_EVENT[i],
//    each gated by its mcountinhibit bit. CSR write to counter half overrides that cycle's increment.
//  - Trap (TRAP_VALID): mepc=TRAP_PC&~3, mcause={IS_INT,CAUSE}, mtval=TRAP_TVAL, MPIE=MIE, MIE=0.
//  - MRET: MIE=MPIE, MPIE=1.  Priority same cycle: TRAP > MRET > CSR write (lower ones dropped).
//  - TRAP_TARGET = {mtvec[31:2],2'b00} + ((mtvec[0] && TRAP_IS_INT) ? TRAP_CAUSE[3:0]<<2 : 0).
//  - IRQ_REQ = mstatus.MIE && |(mie & mip); IRQ_CODE per priority, 0 when none.
//  - RST mid-operation discards any in-flight write, trap or MRET in that cycle.
// TESTING
//  - CSRRW mscratch SRC=32'hDEAD_BEEF, then CSRRS SRC=32'h0000_00F0 -> second read 32'hDEAD_BEEF, mscratch=32'hDEAD_BEFF.
//  - CSRRW mcycle (0xB00) with WR_EN=0 reads count; write to 0xC00 -> CSR_ILLEGAL=1, no change; 0x7C0 -> illegal.
//  - mtvec=32'h8000_0001, IRQ_TIMER=1, mie=0x80, MIE=1 -> IRQ_REQ=1, IRQ_CODE=7, trap -> TARGET 32'h8000_001C, MIE=0, MPIE=1.
//  - mcountinhibit=0x4 for 10 cycles with INSN_RETIRE=1 -> minstret unchanged, mcycle +10.
//  - mcycle written 32'hFFFF_FFFF -> next cycle mcycle=0, mcycleh incremented by 1.
//  - TRAP_VALID, MRET and CSRRW mstatus same cycle -> only trap effects; mepc=TRAP_PC&~3.

Source files
------------

// File: rtl/csr_unit_m.sv
// Machine-mode CSR file: CSRRW/RS/RC execution, trap entry and MRET, interrupt
// arbitration and the machine counters. Lives at WB and feeds the redirect logic.
module csr_unit_m #(
    parameter int          NUM_HPM     = 3,
    parameter bit          VECTOR_EN   = 1'b1,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   CSR_VALID,
    input  logic [1:0]                             CSR_OP,
    input  logic [11:0]                            CSR_ADDR,
    input  logic [31:0]                            CSR_SRC,
    input  logic                                   CSR_WR_EN,
    input  logic                                   INSN_RETIRE,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] HPM_EVENT,
    input  logic                                   IRQ_SW,
    input  logic                                   IRQ_TIMER,
    input  logic                                   IRQ_EXT,
    input  logic                                   TRAP_VALID,
    input  logic                                   TRAP_IS_INT,
    input  logic [30:0]                            TRAP_CAUSE,
    input  logic [31:0]                            TRAP_PC,
    input  logic [31:0]                            TRAP_TVAL,
    input  logic                                   MRET,
    output logic [31:0]                            CSR_RDATA_REG,
    output logic                                   CSR_ILLEGAL,
    output logic [31:0]                            TRAP_TARGET,
    output logic [31:0]                            MEPC_OUT,
    output logic                                   IRQ_REQ,
    output logic [3:0]                             IRQ_CODE
);
    localparam int          HPM_N      = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] MTVEC_MASK = VECTOR_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
    localparam logic [31:0] INH_MASK   = 32'h0000_0005 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic        r_st_mie, r_st_mpie;
    logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_minhibit;
    logic [63:0] r_mcycle, r_minstret;
    logic [63:0] r_hpm [HPM_N];
    logic [31:0] r_rdata;
    logic        r_illegal;

    logic        w_access, w_known, w_legal, w_write, w_cnt_lo, w_cnt_hi;
    logic [31:0] w_old, w_wdata, w_mip, w_pend;

    // An access is CSR_VALID with a non-zero CSR_OP. There is no backpressure: one
    // access is accepted every cycle and its old value and legality appear next cycle.
    assign w_access = CSR_VALID && (CSR_OP != 2'b00);
    assign w_cnt_lo = (CSR_ADDR[11:5] == 7'h58);
    assign w_cnt_hi = (CSR_ADDR[11:5] == 7'h5C);
    assign w_mip    = {20'h0, IRQ_EXT, 3'h0, IRQ_TIMER, 3'h0, IRQ_SW, 3'h0};
    assign w_pend   = r_mie & w_mip;

    always_comb begin
        w_known = 1'b1;
        w_old   = 32'h0;
        case (CSR_ADDR)
            12'h300: w_old = {19'h0, 2'b11, 3'h0, r_st_mpie, 3'h0, r_st_mie, 3'h0};
            12'h304: w_old = r_mie;
            12'h305: w_old = r_mtvec;
            12'h320: w_old = r_minhibit;
            12'h340: w_old = r_mscratch;
            12'h341: w_old = r_mepc;
            12'h342: w_old = r_mcause;
            12'h343: w_old = r_mtval;
            12'h344: w_old = w_mip;
            default: begin
                if (w_cnt_lo || w_cnt_hi) begin
                    // Slot 1 would be the time counter, which lives outside this unit.
                    w_known = (CSR_ADDR[4:0] != 5'd1);
                    if (CSR_ADDR[4:0] == 5'd0) begin
                        w_old = w_cnt_hi ? r_mcycle[63:32] : r_mcycle[31:0];
                    end else if (CSR_ADDR[4:0] == 5'd2) begin
                        w_old = w_cnt_hi ? r_minstret[63:32] : r_minstret[31:0];
                    end
                    for (int i = 0; i < NUM_HPM; i++) begin
                        if (CSR_ADDR[4:0] == 5'(i + 3)) begin
                            w_old = w_cnt_hi ? r_hpm[i][63:32] : r_hpm[i][31:0];
                        end
                    end
                end else begin
                    w_known = (CSR_ADDR[11:5] == 7'h19) && (CSR_ADDR[4:0] >= 5'd3);
                end
            end
        endcase
    end

    always_comb begin
        case (CSR_OP)
            2'b01:   w_wdata = CSR_SRC;
            2'b10:   w_wdata = w_old | CSR_SRC;
            default: w_wdata = w_old & ~CSR_SRC;
        endcase
    end

    assign w_legal = w_known && !(CSR_WR_EN && (CSR_ADDR[11:10] == 2'b11));
    assign w_write = w_access && w_legal && CSR_WR_EN && !TRAP_VALID && !MRET;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_st_mie   <= 1'b0;
            r_st_mpie  <= 1'b0;
            r_mie      <= 32'h0;
            r_mtvec    <= RESET_MTVEC & MTVEC_MASK;
            r_mscratch <= 32'h0;
            r_mepc     <= 32'h0;
            r_mcause   <= 32'h0;
            r_mtval    <= 32'h0;
            r_minhibit <= 32'h0;
            r_mcycle   <= 64'h0;
            r_minstret <= 64'h0;
            for (int i = 0; i < HPM_N; i++) r_hpm[i] <= 64'h0;
            r_rdata    <= 32'h0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_access) r_rdata <= w_legal ? w_old : 32'h0;
            r_illegal <= w_access && !w_legal;

            if (!r_minhibit[0]) r_mcycle <= r_mcycle + 64'd1;
            if (!r_minhibit[2] && INSN_RETIRE) r_minstret <= r_minstret + 64'd1;
            for (int i = 0; i < NUM_HPM; i++) begin
                if (!r_minhibit[i + 3] && HPM_EVENT[i]) r_hpm[i] <= r_hpm[i] + 64'd1;
            end

            // A counter write lands after the increments so it replaces them for this cycle.
            if (w_write) begin
                case (CSR_ADDR)
                    12'h300: begin
                        r_st_mie  <= w_wdata[3];
                        r_st_mpie <= w_wdata[7];
                    end
                    12'h304: r_mie      <= w_wdata & 32'h0000_0888;
                    12'h305: r_mtvec    <= w_wdata & MTVEC_MASK;
                    12'h320: r_minhibit <= w_wdata & INH_MASK;
                    12'h340: r_mscratch <= w_wdata;
                    12'h341: r_mepc     <= w_wdata & 32'hFFFF_FFFC;
                    12'h342: r_mcause   <= w_wdata;
                    12'h343: r_mtval    <= w_wdata;
                    12'hB00: r_mcycle   <= {r_mcycle[63:32], w_wdata};
                    12'hB80: r_mcycle   <= {w_wdata, r_mcycle[31:0]};
                    12'hB02: r_minstret <= {r_minstret[63:32], w_wdata};
                    12'hB82: r_minstret <= {w_wdata, r_minstret[31:0]};
                    default: begin
                        for (int i = 0; i < NUM_HPM; i++) begin
                            if (CSR_ADDR == 12'hB03 + 12'(i)) r_hpm[i] <= {r_hpm[i][63:32], w_wdata};
                            else if (CSR_ADDR == 12'hB83 + 12'(i)) r_hpm[i] <= {w_wdata, r_hpm[i][31:0]};
                        end
                    end
                endcase
            end

            if (TRAP_VALID) begin
                r_mepc    <= TRAP_PC & 32'hFFFF_FFFC;
                r_mcause  <= {TRAP_IS_INT, TRAP_CAUSE};
                r_mtval   <= TRAP_TVAL;
                r_st_mpie <= r_st_mie;
                r_st_mie  <= 1'b0;
            end else if (MRET) begin
                r_st_mie  <= r_st_mpie;
                r_st_mpie <= 1'b1;
            end
        end
    end

    assign CSR_RDATA_REG = r_rdata;
    assign CSR_ILLEGAL   = r_illegal;
    assign MEPC_OUT      = r_mepc;
    assign TRAP_TARGET   = {r_mtvec[31:2], 2'b00} +
                           ((r_mtvec[0] && TRAP_IS_INT) ? {26'h0, TRAP_CAUSE[3:0], 2'b00} : 32'h0);
    assign IRQ_REQ       = r_st_mie && (|w_pend);
    assign IRQ_CODE      = w_pend[11] ? 4'd11 : w_pend[3] ? 4'd3 : w_pend[7] ? 4'd7 : 4'd0;
endmodule

// File: tb/tb_csr_unit_m.sv
// Bench for csr_unit_m: directed scenarios plus randomized accesses against a
// CSR-level reference model of the machine-mode register file.
module tb_csr_unit_m;
    localparam int NUM_HPM = 3;

    logic        CLK = 1'b0;
    logic        RST, CSR_VALID, CSR_WR_EN, INSN_RETIRE, IRQ_SW, IRQ_TIMER, IRQ_EXT;
    logic        TRAP_VALID, TRAP_IS_INT, MRET;
    logic [1:0]  CSR_OP;
    logic [11:0] CSR_ADDR;
    logic [31:0] CSR_SRC, TRAP_PC, TRAP_TVAL;
    logic [2:0]  HPM_EVENT;
    logic [30:0] TRAP_CAUSE;
    wire  [31:0] CSR_RDATA_REG, TRAP_TARGET, MEPC_OUT;
    wire         CSR_ILLEGAL, IRQ_REQ;
    wire  [3:0]  IRQ_CODE;

    csr_unit_m #(.NUM_HPM(NUM_HPM), .VECTOR_EN(1'b1), .RESET_MTVEC(32'h0)) dut (
        .CLK(CLK), .RST(RST), .CSR_VALID(CSR_VALID), .CSR_OP(CSR_OP), .CSR_ADDR(CSR_ADDR),
        .CSR_SRC(CSR_SRC), .CSR_WR_EN(CSR_WR_EN), .INSN_RETIRE(INSN_RETIRE), .HPM_EVENT(HPM_EVENT),
        .IRQ_SW(IRQ_SW), .IRQ_TIMER(IRQ_TIMER), .IRQ_EXT(IRQ_EXT), .TRAP_VALID(TRAP_VALID),
        .TRAP_IS_INT(TRAP_IS_INT), .TRAP_CAUSE(TRAP_CAUSE), .TRAP_PC(TRAP_PC), .TRAP_TVAL(TRAP_TVAL),
        .MRET(MRET), .CSR_RDATA_REG(CSR_RDATA_REG), .CSR_ILLEGAL(CSR_ILLEGAL),
        .TRAP_TARGET(TRAP_TARGET), .MEPC_OUT(MEPC_OUT), .IRQ_REQ(IRQ_REQ), .IRQ_CODE(IRQ_CODE)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: architectural CSR state, counters indexed by counter number.
    bit          m_ie, m_pie;
    logic [31:0] m_mie, m_mtvec, m_scratch, m_epc, m_cause, m_tval, m_inh;
    logic [63:0] m_cnt [32];
    logic [31:0] exp_rdata;
    bit          exp_ill;
    logic [31:0] snap_i, snap_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cnt_impl(input int k);
        return (k == 0) || (k == 2) || (k >= 3 && k < 3 + NUM_HPM);
    endfunction

    function automatic bit is_cnt_addr(input logic [11:0] a);
        return (a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F);
    endfunction

    function automatic bit m_known(input logic [11:0] a);
        if (a inside {12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344})
            return 1'b1;
        if (a >= 12'h323 && a <= 12'h33F) return 1'b1;
        if (is_cnt_addr(a)) return a[4:0] != 5'd1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mip_now();
        return {20'h0, IRQ_EXT, 3'h0, IRQ_TIMER, 3'h0, IRQ_SW, 3'h0};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {19'h0, 2'b11, 3'h0, m_pie, 3'h0, m_ie, 3'h0};
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h320: return m_inh;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return mip_now();
            default: begin
                if (is_cnt_addr(a)) return a[7] ? m_cnt[a[4:0]][63:32] : m_cnt[a[4:0]][31:0];
                return 32'h0;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_ie = 0; m_pie = 0;
        m_mie = 0; m_mtvec = 0; m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_inh = 0;
        for (int k = 0; k < 32; k++) m_cnt[k] = 64'h0;
        exp_rdata = 0; exp_ill = 0;
    endtask

    // Applies one clock edge of architectural effects using the inputs presented to it.
    task automatic model_step();
        logic [31:0] old, wd;
        bit acc, legal, wr, inc;
        int wk;
        if (RST) begin
            model_reset();
            return;
        end
        acc   = CSR_VALID && (CSR_OP != 2'b00);
        legal = m_known(CSR_ADDR) && !(CSR_WR_EN && CSR_ADDR[11:10] == 2'b11);
        old   = m_read(CSR_ADDR);
        if (acc) exp_rdata = legal ? old : 32'h0;
        exp_ill = acc && !legal;
        case (CSR_OP)
            2'b01:   wd = CSR_SRC;
            2'b10:   wd = old | CSR_SRC;
            default: wd = old & ~CSR_SRC;
        endcase
        wr = acc && legal && CSR_WR_EN && !TRAP_VALID && !MRET;
        wk = (wr && is_cnt_addr(CSR_ADDR) && cnt_impl(int'(CSR_ADDR[4:0]))) ? int'(CSR_ADDR[4:0]) : -1;
        for (int k = 0; k < 32; k++) begin
            inc = 1'b0;
            if (k == 0) inc = 1'b1;
            else if (k == 2) inc = INSN_RETIRE;
            else if (k >= 3 && k < 3 + NUM_HPM) inc = HPM_EVENT[k - 3];
            if (m_inh[k]) inc = 1'b0;
            if (k != wk && inc) m_cnt[k] = m_cnt[k] + 64'd1;
        end
        if (wk >= 0) begin
            if (CSR_ADDR[7]) m_cnt[wk][63:32] = wd;
            else m_cnt[wk][31:0] = wd;
        end else if (wr) begin
            case (CSR_ADDR)
                12'h300: begin m_ie = wd[3]; m_pie = wd[7]; end
                12'h304: m_mie = wd & 32'h888;
                12'h305: m_mtvec = wd & 32'hFFFF_FFFD;
                12'h320: m_inh = wd & 32'h0000_003D;
                12'h340: m_scratch = wd;
                12'h341: m_epc = wd & ~32'h3;
                12'h342: m_cause = wd;
                12'h343: m_tval = wd;
                default: ;
            endcase
        end
        if (TRAP_VALID) begin
            m_epc = TRAP_PC & ~32'h3;
            m_cause = {TRAP_IS_INT, TRAP_CAUSE};
            m_tval = TRAP_TVAL;
            m_pie = m_ie;
            m_ie = 1'b0;
        end else if (MRET) begin
            m_ie = m_pie;
            m_pie = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [31:0] pend, tgt;
        logic [3:0]  code;
        pend = m_mie & mip_now();
        if (pend[11]) code = 4'd11;
        else if (pend[3]) code = 4'd3;
        else if (pend[7]) code = 4'd7;
        else code = 4'd0;
        tgt = (m_mtvec & ~32'h3) + ((m_mtvec[0] && TRAP_IS_INT) ? 32'(TRAP_CAUSE[3:0]) * 4 : 32'h0);
        chk("rdata", CSR_RDATA_REG, exp_rdata);
        chk("illegal", CSR_ILLEGAL, exp_ill);
        chk("irq_req", IRQ_REQ, m_ie && (pend != 0));
        chk("irq_code", IRQ_CODE, code);
        chk("mepc_out", MEPC_OUT, m_epc);
        chk("trap_target", TRAP_TARGET, tgt);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_all();
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s, input bit we);
        CSR_VALID = 1'b1; CSR_OP = op; CSR_ADDR = a; CSR_SRC = s; CSR_WR_EN = we;
        tick();
        CSR_VALID = 1'b0; CSR_OP = 2'b00; CSR_WR_EN = 1'b0;
    endtask

    initial begin
        RST = 1; CSR_VALID = 0; CSR_OP = 0; CSR_ADDR = 0; CSR_SRC = 0; CSR_WR_EN = 0;
        INSN_RETIRE = 0; HPM_EVENT = 0; IRQ_SW = 0; IRQ_TIMER = 0; IRQ_EXT = 0;
        TRAP_VALID = 0; TRAP_IS_INT = 0; TRAP_CAUSE = 0; TRAP_PC = 0; TRAP_TVAL = 0; MRET = 0;
        repeat (3) tick();
        chk("rst_rdata", CSR_RDATA_REG, 32'h0);
        chk("rst_illegal", CSR_ILLEGAL, 1'b0);
        chk("rst_irq", IRQ_REQ, 1'b0);
        RST = 0;
        csr(2'b10, 12'h300, 32'h0, 0);
        chk("rst_mstatus", CSR_RDATA_REG, 32'h0000_1800);
        csr(2'b10, 12'h305, 32'h0, 0);
        chk("rst_mtvec", CSR_RDATA_REG, 32'h0);

        // mscratch RW then RS
        csr(2'b01, 12'h340, 32'hDEAD_BEEF, 1);
        csr(2'b10, 12'h340, 32'h0000_00F0, 1);
        chk("scratch_rs_old", CSR_RDATA_REG, 32'hDEAD_BEEF);
        csr(2'b10, 12'h340, 32'h0, 0);
        chk("scratch_new", CSR_RDATA_REG, 32'hDEAD_BEFF);

        // counter read without write, read-only and unimplemented addresses
        csr(2'b01, 12'hB00, 32'h0, 0);
        chk("mcycle_rd_legal", CSR_ILLEGAL, 1'b0);
        csr(2'b01, 12'hC00, 32'h5, 1);
        chk("c00_illegal", CSR_ILLEGAL, 1'b1);
        csr(2'b10, 12'h7C0, 32'h0, 0);
        chk("7c0_illegal", CSR_ILLEGAL, 1'b1);

        // vectored timer interrupt and trap entry
        csr(2'b01, 12'h305, 32'h8000_0001, 1);
        IRQ_TIMER = 1;
        csr(2'b01, 12'h304, 32'h0000_0080, 1);
        csr(2'b10, 12'h300, 32'h0000_0008, 1);
        chk("irq_req_on", IRQ_REQ, 1'b1);
        chk("irq_code_7", IRQ_CODE, 4'd7);
        TRAP_VALID = 1; TRAP_IS_INT = 1; TRAP_CAUSE = 31'd7; TRAP_PC = 32'h1234_5677; TRAP_TVAL = 32'h0;
        #1;
        chk("trap_target_vec", TRAP_TARGET, 32'h8000_001C);
        tick();
        TRAP_VALID = 0; TRAP_IS_INT = 0; TRAP_CAUSE = 0;
        csr(2'b10, 12'h300, 32'h0, 0);
        chk("trap_mstatus", CSR_RDATA_REG, 32'h0000_1880);
        chk("trap_mepc", MEPC_OUT, 32'h1234_5674);
        chk("irq_masked", IRQ_REQ, 1'b0);
        csr(2'b10, 12'h342, 32'h0, 0);
        chk("trap_mcause", CSR_RDATA_REG, 32'h8000_0007);
        MRET = 1;
        tick();
        MRET = 0;
        chk("mret_irq", IRQ_REQ, 1'b1);
        csr(2'b01, 12'h304, 32'hFFFF_FFFF, 1);
        IRQ_SW = 1; IRQ_EXT = 1;
        #1;
        chk("prio_11", IRQ_CODE, 4'd11);
        IRQ_EXT = 0;
        #1;
        chk("prio_3", IRQ_CODE, 4'd3);
        IRQ_SW = 0; IRQ_TIMER = 0;
        #1;
        chk("prio_none", IRQ_CODE, 4'd0);
        csr(2'b01, 12'h304, 32'h0, 1);

        // minstret inhibited while mcycle runs
        csr(2'b01, 12'h320, 32'h0000_0004, 1);
        INSN_RETIRE = 1;
        csr(2'b01, 12'hB02, 32'h0, 0);
        snap_i = exp_rdata;
        csr(2'b01, 12'hB00, 32'h0, 0);
        snap_c = exp_rdata;
        repeat (9) tick();
        csr(2'b01, 12'hB00, 32'h0, 0);
        chk("inh_mcycle", CSR_RDATA_REG, snap_c + 32'd10);
        csr(2'b01, 12'hB02, 32'h0, 0);
        chk("inh_minstret", CSR_RDATA_REG, snap_i);
        INSN_RETIRE = 0;
        csr(2'b01, 12'h320, 32'h0, 1);

        // mcycle low half wraps into mcycleh
        csr(2'b01, 12'hB80, 32'h0, 1);
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF, 1);
        tick();
        csr(2'b10, 12'hB00, 32'h0, 0);
        chk("wrap_lo", CSR_RDATA_REG, 32'h0);
        csr(2'b10, 12'hB80, 32'h0, 0);
        chk("wrap_hi", CSR_RDATA_REG, 32'h1);

        // trap wins over MRET and CSR write in the same cycle
        csr(2'b10, 12'h300, 32'h0000_0008, 1);
        TRAP_VALID = 1; TRAP_IS_INT = 0; TRAP_CAUSE = 31'd2; TRAP_PC = 32'hABCD_0003;
        TRAP_TVAL = 32'h55; MRET = 1;
        csr(2'b01, 12'h300, 32'h0, 1);
        TRAP_VALID = 0; MRET = 0; TRAP_CAUSE = 0; TRAP_PC = 0; TRAP_TVAL = 0;
        csr(2'b10, 12'h300, 32'h0, 0);
        chk("prio_mstatus", CSR_RDATA_REG, 32'h0000_1880);
        chk("prio_mepc", MEPC_OUT, 32'hABCD_0000);
        csr(2'b10, 12'h343, 32'h0, 0);
        chk("prio_mtval", CSR_RDATA_REG, 32'h55);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [11:0] addrs [25];
            addrs = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342, 12'h343,
                      12'h344, 12'hB00, 12'hB02, 12'hB03, 12'hB05, 12'hB06, 12'hB80, 12'hB82,
                      12'hB83, 12'hB85, 12'hB9F, 12'h323, 12'h33F, 12'hC00, 12'h7C0, 12'h301, 12'hB01};
            RST         = ($urandom_range(0, 63) == 0);
            CSR_VALID   = ($urandom_range(0, 3) != 0);
            CSR_OP      = 2'($urandom_range(0, 3));
            CSR_ADDR    = addrs[$urandom_range(0, 24)];
            CSR_SRC     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            CSR_WR_EN   = ($urandom_range(0, 2) != 0);
            INSN_RETIRE = 1'($urandom_range(0, 1));
            HPM_EVENT   = 3'($urandom_range(0, 7));
            IRQ_SW      = ($urandom_range(0, 3) == 0);
            IRQ_TIMER   = ($urandom_range(0, 3) == 0);
            IRQ_EXT     = ($urandom_range(0, 3) == 0);
            TRAP_VALID  = ($urandom_range(0, 15) == 0);
            TRAP_IS_INT = 1'($urandom_range(0, 1));
            TRAP_CAUSE  = 31'($urandom);
            TRAP_PC     = $urandom;
            TRAP_TVAL   = $urandom;
            MRET        = ($urandom_range(0, 15) == 0);
            tick();
        end
        RST = 0; CSR_VALID = 0; CSR_OP = 0; CSR_WR_EN = 0; TRAP_VALID = 0; MRET = 0;
        INSN_RETIRE = 0; HPM_EVENT = 0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
